booth_radix4_divider_seq: RTL and testbench

//   Sequential signed integer divider; the inverse operation of the radix-4 Booth multiplier in the ALU.

---
 rtl/booth_radix4_divider_seq.sv | 113 +++++++++++
 tb/tb_booth_radix4_divider_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/booth_radix4_divider_seq.sv
// booth_radix4_divider_seq: sequential signed divider, non-restoring, one quotient bit per cycle
// Ports:
//    clk, rst_n        rising-edge clock, asynchronous active-low reset
//    start             request, sampled only while idle
//    D_N, D_D          signed dividend and divisor, captured when start is accepted
//    busy              high from INIT through DONE
//    done              one-cycle pulse when Q, R and the flags are valid
//    Q, R              signed quotient (truncated toward zero) and remainder (sign of dividend)
//    div_by_zero       set with done when D_D==0 (Q all ones, R=D_N)
//    overflow          set with done for -2^(W-1) / -1 (Q wraps to -2^(W-1), R=0)
module booth_radix4_divider_seq #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] D_N,
   input  logic [W-1:0] D_D,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] Q,
   output logic [W-1:0] R,
   output logic         div_by_zero,
   output logic         overflow
);
   localparam int CW = $clog2(W + 1);
   typedef enum logic [2:0] {S_IDLE, S_INIT, S_ITER, S_CORR, S_SIGN, S_DONE} state_t;
   state_t r_state, w_next;
   logic [W-1:0] r_n, r_d, r_qr;
   logic [W:0] r_a, r_m;
   logic [CW-1:0] r_cnt;
   logic [W:0] w_n_ext, w_d_ext, w_n_mag, w_d_mag, w_shift, w_a_step;
   logic w_sq, w_sr, w_dbz, w_ovf;
   // magnitudes at W+1 bits so that |-2^(W-1)| is representable
   assign w_n_ext = {r_n[W-1], r_n};
   assign w_d_ext = {r_d[W-1], r_d};
   assign w_n_mag = r_n[W-1] ? -w_n_ext : w_n_ext;
   assign w_d_mag = r_d[W-1] ? -w_d_ext : w_d_ext;
   assign w_sq = r_n[W-1] ^ r_d[W-1];
   assign w_sr = r_n[W-1];
   assign w_dbz = r_d == '0;
   assign w_ovf = (r_n == {1'b1, {(W-1){1'b0}}}) && (r_d == '1);
   // shifted partial remainder stays within W+1 bits because |A| < M <= 2^(W-1)
   assign w_shift = {r_a[W-1:0], r_qr[W-1]};
   assign w_a_step = r_a[W] ? w_shift + r_m : w_shift - r_m;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else r_state <= w_next;
   end
   // a zero divisor skips the iterations but still passes through SIGN to publish its result
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_next = S_INIT;
         S_INIT: w_next = w_dbz ? S_SIGN : S_ITER;
         S_ITER: if (r_cnt == CW'(1)) w_next = S_CORR;
         S_CORR: w_next = S_SIGN;
         S_SIGN: w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end
   always_comb begin
      busy = r_state != S_IDLE;
      done = r_state == S_DONE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_n <= '0;
         r_d <= '0;
         r_qr <= '0;
         r_a <= '0;
         r_m <= '0;
         r_cnt <= '0;
         Q <= '0;
         R <= '0;
         div_by_zero <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_n <= D_N;
               r_d <= D_D;
               Q <= '0;
               R <= '0;
               div_by_zero <= 1'b0;
               overflow <= 1'b0;
            end
            S_INIT: begin
               r_a <= '0;
               r_qr <= w_n_mag[W-1:0];
               r_m <= w_d_mag;
               r_cnt <= CW'(W);
            end
            S_ITER: begin
               r_a <= w_a_step;
               r_qr <= {r_qr[W-2:0], ~w_a_step[W]};
               r_cnt <= r_cnt - 1'b1;
            end
            S_CORR: if (r_a[W]) r_a <= r_a + r_m;
            S_SIGN: if (w_dbz) begin
               Q <= '1;
               R <= r_n;
               div_by_zero <= 1'b1;
            end else begin
               Q <= w_sq ? -r_qr : r_qr;
               R <= w_sr ? -r_a[W-1:0] : r_a[W-1:0];
               overflow <= w_ovf;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_radix4_divider_seq.sv
// tb_booth_radix4_divider_seq: randomized and directed check of the signed sequential divider
module tb_booth_radix4_divider_seq;
   localparam int W = 8;
   localparam int MINV = -(1 << (W - 1));
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [W-1:0] D_N = '0, D_D = '0, Q, R;
   logic busy, done, div_by_zero, overflow;
   int n_vec = 0, n_err = 0;
   booth_radix4_divider_seq #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .D_N(D_N), .D_D(D_D),
      .busy(busy), .done(done), .Q(Q), .R(R),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic void model(input int n, input int d, output int q, output int r, output int dbz, output int ovf);
      dbz = int'(d == 0);
      ovf = int'(n == MINV && d == -1);
      if (dbz != 0) begin q = -1; r = n; end
      else if (ovf != 0) begin q = MINV; r = 0; end
      else begin q = n / d; r = n % d; end
   endfunction
   function automatic int rnd();
      return int'($urandom_range(2 ** W - 1)) + MINV;
   endfunction
   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!done && cyc < 40);
   endtask
   task automatic op(input int n, input int d);
      int q, r, dbz, ovf, cyc;
      model(n, d, q, r, dbz, ovf);
      D_N = n[W-1:0];
      D_D = d[W-1:0];
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy", busy, 1);
      wait_done(cyc);
      chk("latency", cyc, d == 0 ? 2 : W + 3);
      chk("Q", $signed(Q), q);
      chk("R", $signed(R), r);
      chk("dbz", div_by_zero, dbz);
      chk("ovf", overflow, ovf);
      @(posedge clk);
      #1 chk("idle", busy, 0);
   endtask
   int tn[7] = '{7, -7, 7, -7, MINV, MINV, 45};
   int td[7] = '{3, 3, -3, -3, -1, 1, 0};
   initial begin
      int n, d, q, r, dbz, ovf, cyc, seen;
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst Q", $signed(Q), 0);
      chk("rst R", $signed(R), 0);
      chk("rst dbz", div_by_zero, 0);
      chk("rst ovf", overflow, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      foreach (tn[i]) op(tn[i], td[i]);
      D_N = 8'd100;
      D_D = 8'd7;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      D_N = 8'd1;
      D_D = 8'd1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(cyc);
      chk("ign latency", cyc + 4, W + 3);
      chk("ign Q", $signed(Q), 14);
      chk("ign R", $signed(R), 2);
      @(posedge clk);
      #1;
      D_N = -8'sd100;
      D_D = 8'd9;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid rst busy", busy, 0);
      chk("mid rst done", done, 0);
      chk("mid rst Q", $signed(Q), 0);
      chk("mid rst R", $signed(R), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1 seen += int'(done);
      end
      chk("no done after rst", seen, 0);
      n = rnd();
      do d = rnd(); while (d == 0);
      D_N = n[W-1:0];
      D_D = d[W-1:0];
      start = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         model(n, d, q, r, dbz, ovf);
         wait_done(cyc);
         chk("b2b latency", cyc, i == 0 ? W + 4 : W + 5);
         chk("b2b Q", $signed(Q), q);
         chk("b2b R", $signed(R), r);
         chk("b2b ovf", overflow, ovf);
         chk("b2b dbz", div_by_zero, dbz);
         n = rnd();
         do d = rnd(); while (d == 0);
         D_N = n[W-1:0];
         D_D = d[W-1:0];
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
